audio_dac_serializer: RTL and testbench

//  Transmit side of the codec audio link: takes filtered stereo samples (L/R, two's complement)

---
 rtl/audio_dac_serializer_if.sv | 23 ++
 rtl/audio_dac_serializer.sv | 127 ++++++++++++
 tb/tb_audio_dac_serializer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_serializer_if.sv
// Sample handshake between the filter bank (master) and the DAC serializer (slave).
interface audio_dac_serializer_if #(
    parameter int unsigned WORD_LENGTH = 16
);
    logic [WORD_LENGTH-1:0] sample_L;
    logic [WORD_LENGTH-1:0] sample_R;
    logic                   sample_valid;
    logic                   sample_ready;

    modport master (
        output sample_L,
        output sample_R,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_L,
        input  sample_R,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Serializes stereo samples MSB-first onto the codec DAC pins; BCLK/LRCK are generated from clk.
// Define DAC_I2S_DELAY_EN for I2S framing (MSB one BCLK after LRCK); default is left-justified.
module audio_dac_serializer #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned BCLK_DIV    = 2,
    parameter int unsigned SLOT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_dac_serializer_if.slave smp,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int unsigned FrameBits = 2 * SLOT_BITS;
    localparam int unsigned CntW      = $clog2(FrameBits);
    localparam int unsigned DivW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned IdxW      = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam int          SlotInt   = int'(SLOT_BITS);
    localparam int          WordInt   = int'(WORD_LENGTH);

`ifdef DAC_I2S_DELAY_EN
    localparam int SlotDelay = 1;
`else
    localparam int SlotDelay = 0;
`endif

    logic [DivW-1:0]        div_cnt_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic [CntW-1:0]        bit_cnt_d;
    logic [WORD_LENGTH-1:0] hold_l_q, hold_r_q;
    logic [WORD_LENGTH-1:0] shift_l_q, shift_r_q;
    logic [WORD_LENGTH-1:0] last_l_q, last_r_q;
    logic [WORD_LENGTH-1:0] load_l, load_r;
    logic [WORD_LENGTH-1:0] slot_word;
    logic                   div_wrap;
    logic                   fall_event;
    logic                   frame_load;
    logic                   accept;
    logic                   in_right;
    logic                   dat_d;
    int                     slot_pos;

    always_comb begin
        div_wrap   = (div_cnt_q == DivW'(BCLK_DIV - 1));
        fall_event = div_wrap && AUD_BCLK;
        bit_cnt_d  = (bit_cnt_q == CntW'(FrameBits - 1)) ? '0 : bit_cnt_q + CntW'(1);
        frame_load = fall_event && (bit_cnt_d == '0);
        // On the load clk an empty holding register is bypassed instead of written.
        accept     = smp.sample_valid && smp.sample_ready && !frame_load;

        if (!smp.sample_ready) begin
            load_l = hold_l_q;
            load_r = hold_r_q;
        end else if (smp.sample_valid) begin
            load_l = smp.sample_L;
            load_r = smp.sample_R;
        end else begin
            load_l = last_l_q;
            load_r = last_r_q;
        end

        in_right  = (bit_cnt_d >= CntW'(SLOT_BITS));
        slot_word = frame_load ? load_l : shift_l_q;
        if (in_right) begin
            slot_word = shift_r_q;
        end

        slot_pos = int'(bit_cnt_d) - (in_right ? SlotInt : 0) - SlotDelay;
        dat_d    = 1'b0;
        if (slot_pos >= 0 && slot_pos < WordInt) begin
            dat_d = slot_word[IdxW'(WordInt - 1 - slot_pos)];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q        <= '0;
            bit_cnt_q        <= CntW'(FrameBits - 1);
            AUD_BCLK         <= 1'b0;
            AUD_DACLRCK      <= 1'b0;
            AUD_DACDAT       <= 1'b0;
            frame_start      <= 1'b0;
            underrun         <= 1'b0;
            smp.sample_ready <= 1'b1;
            hold_l_q         <= '0;
            hold_r_q         <= '0;
            shift_l_q        <= '0;
            shift_r_q        <= '0;
            last_l_q         <= '0;
            last_r_q         <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            div_cnt_q   <= div_wrap ? '0 : div_cnt_q + DivW'(1);
            if (div_wrap) begin
                AUD_BCLK <= ~AUD_BCLK;
            end

            if (accept) begin
                hold_l_q         <= smp.sample_L;
                hold_r_q         <= smp.sample_R;
                smp.sample_ready <= 1'b0;
            end

            if (fall_event) begin
                bit_cnt_q   <= bit_cnt_d;
                AUD_DACLRCK <= in_right;
                AUD_DACDAT  <= dat_d;
            end

            if (frame_load) begin
                shift_l_q        <= load_l;
                shift_r_q        <= load_r;
                last_l_q         <= load_l;
                last_r_q         <= load_r;
                smp.sample_ready <= 1'b1;
                frame_start      <= 1'b1;
                underrun         <= smp.sample_ready && !smp.sample_valid;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized bench: a frame-level model predicts every pin from the clk count since reset
// release and the list of frames the source should have delivered.
module tb_audio_dac_serializer;

    localparam int WL        = 16;
    localparam int DIV       = 2;
    localparam int SLOT      = 32;
    localparam int BCLK_PER  = 2 * DIV;
    localparam int FRAME_CLK = BCLK_PER * 2 * SLOT;

`ifdef DAC_I2S_DELAY_EN
    localparam int DELAY = 1;
`else
    localparam int DELAY = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic bclk, lrck, dat, fs, ur;

    audio_dac_serializer_if #(.WORD_LENGTH(WL)) smp_if ();

    audio_dac_serializer #(
        .WORD_LENGTH(WL),
        .BCLK_DIV   (DIV),
        .SLOT_BITS  (SLOT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .smp        (smp_if),
        .AUD_BCLK   (bclk),
        .AUD_DACLRCK(lrck),
        .AUD_DACDAT (dat),
        .frame_start(fs),
        .underrun   (ur)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, got, exp, $time);
        end
    endtask

    // Model state
    int              t;
    logic [2*WL-1:0] frames[$];
    logic [2*WL-1:0] hold_s;
    logic [2*WL-1:0] last_s;
    bit              hold_full;
    bit              last_ur;

    // Source state
    bit              src_pending;
    int              next_at;
    int              n_offered;
    logic [WL-1:0]   src_l, src_r;

    function automatic bit is_load(input int te);
        return te >= BCLK_PER && (te - BCLK_PER) % FRAME_CLK == 0;
    endfunction

    function automatic int next_load_after(input int te);
        if (te < BCLK_PER) return BCLK_PER;
        return BCLK_PER + FRAME_CLK * ((te - BCLK_PER) / FRAME_CLK + 1);
    endfunction

    task automatic model_reset();
        t         = 0;
        frames.delete();
        hold_s    = '0;
        last_s    = '0;
        hold_full = 1'b0;
        last_ur   = 1'b0;
    endtask

    task automatic model_step(output bit took);
        logic [2*WL-1:0] f;
        took = 1'b0;
        if (is_load(t)) begin
            if (hold_full) begin
                f         = hold_s;
                hold_full = 1'b0;
                last_ur   = 1'b0;
            end else if (src_pending) begin
                f       = {src_l, src_r};
                took    = 1'b1;
                last_ur = 1'b0;
            end else begin
                f       = last_s;
                last_ur = 1'b1;
            end
            last_s = f;
            frames.push_back(f);
        end else if (src_pending && !hold_full) begin
            hold_s    = {src_l, src_r};
            hold_full = 1'b1;
            took      = 1'b1;
        end
    endtask

    task automatic schedule_next();
        int r;
        src_pending = 1'b0;
        r = int'($urandom_range(0, 3));
        if (n_offered == 2) next_at = t + 2 * FRAME_CLK;
        else if (r == 0)   next_at = t + 1;
        else if (r == 1)   next_at = next_load_after(t);
        else               next_at = t + int'($urandom_range(1, 2 * FRAME_CLK));
    endtask

    task automatic drive_src();
        if (!src_pending && (t + 1) >= next_at) begin
            src_pending = 1'b1;
            n_offered++;
            if (n_offered == 1) begin
                src_l = 16'hA5C3;
                src_r = 16'h8001;
            end else if (n_offered == 2) begin
                src_l = 16'h7FFF;
                src_r = 16'($urandom);
            end else begin
                src_l = 16'($urandom);
                src_r = 16'($urandom);
            end
        end
        smp_if.sample_valid = src_pending;
        smp_if.sample_L     = src_pending ? src_l : 16'($urandom);
        smp_if.sample_R     = src_pending ? src_r : 16'($urandom);
    endtask

    task automatic check_outputs();
        int              k, bc, n, p;
        logic [2*WL-1:0] f;
        logic [WL-1:0]   w;
        logic            e_lrck, e_dat;
        e_lrck = 1'b0;
        e_dat  = 1'b0;
        if (t >= BCLK_PER) begin
            k      = t / BCLK_PER;
            bc     = (k - 1) % (2 * SLOT);
            n      = (k - 1) / (2 * SLOT);
            f      = frames[n];
            e_lrck = (bc >= SLOT);
            w      = e_lrck ? f[WL-1:0] : f[2*WL-1:WL];
            p      = bc % SLOT - DELAY;
            if (p >= 0 && p < WL) e_dat = w[WL-1-p];
        end
        check_eq("bclk", 32'(bclk), 32'((t / DIV) % 2));
        check_eq("lrck", 32'(lrck), 32'(e_lrck));
        check_eq("dacdat", 32'(dat), 32'(e_dat));
        check_eq("frame_start", 32'(fs), 32'(is_load(t)));
        check_eq("underrun", 32'(ur), 32'(is_load(t) && last_ur));
        check_eq("ready", 32'(smp_if.sample_ready), 32'(!hold_full));
    endtask

    task automatic run(input int edges);
        bit took;
        repeat (edges) begin
            @(posedge clk);
            t++;
            model_step(took);
            if (took) schedule_next();
            #1 check_outputs();
            @(negedge clk);
            drive_src();
        end
    endtask

    initial begin
        model_reset();
        src_pending = 1'b0;
        n_offered   = 0;
        next_at     = 100;
        drive_src();

        repeat (3) @(negedge clk);
        check_outputs();
        reset = 1'b1;
        run(8 * FRAME_CLK);

        // Stop inside the right slot, then reset asynchronously between clk edges.
        for (int i = 0; i < FRAME_CLK && (t - BCLK_PER) % FRAME_CLK != 200; i++) run(1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        if (!src_pending) next_at = int'($urandom_range(1, 300));
        repeat (2) @(negedge clk);
        check_outputs();
        drive_src();
        reset = 1'b1;
        run(5 * FRAME_CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
